// File: rtl/id_ex_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_reg_pkg
// Purpose  : Shared encodings for the dual-issue ID/EX pipeline register.
//            Holds the "not a load" / "not a store" type codes, the two-state
//            issue FSM encoding and a saturating-increment helper for the
//            bubble performance counter.
// Revision : 1.0 - initial release
// ============================================================================
package id_ex_reg_pkg;

    // Load / store type codes meaning "this instruction is not a load/store".
    localparam int unsigned c_LD_TYPE_W = 3;
    localparam int unsigned c_ST_TYPE_W = 2;
    localparam logic [c_LD_TYPE_W-1:0] c_LD_XXX = 3'b000;
    localparam logic [c_ST_TYPE_W-1:0] c_ST_XXX = 2'b00;

    // Issue FSM: PAIR issues both slots, SECOND issues the held slot 1 of a
    // pair whose slot 0 went out the previous cycle.
    localparam logic [0:0] c_IDEX_ST_PAIR   = 1'b0;
    localparam logic [0:0] c_IDEX_ST_SECOND = 1'b1;

    // Width of the bubble performance counter.
    localparam int unsigned c_BUBBLE_CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [c_BUBBLE_CNT_W-1:0] f_sat_inc(
        input logic [c_BUBBLE_CNT_W-1:0] i_val
    );
        f_sat_inc = (&i_val) ? i_val : i_val + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_reg_slot.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_slot
// Purpose  : One issue slot of the ID/EX register. A plain field register
//            with three controls, in priority order:
//              rst      - clear every field to its reset value
//              i_bubble - turn the slot into a bubble (control fields only;
//                         data fields keep their previous, don't-care values)
//              i_load   - capture the decode-stage fields
//            With none of them active every field holds.
// Ports    : clk, rst; i_load, i_bubble; i_* decode fields; o_* registered
//            copies of the fields.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_slot #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned RF_ADDR_WIDTH = 5,
    parameter int unsigned ALU_OP_WIDTH  = 5,
    parameter int unsigned LD_TYPE_WIDTH = 3,
    parameter int unsigned ST_TYPE_WIDTH = 2,
    parameter logic [LD_TYPE_WIDTH-1:0] LD_BUBBLE = '0,
    parameter logic [ST_TYPE_WIDTH-1:0] ST_BUBBLE = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic                     i_bubble,
    input  logic                     i_valid,
    input  logic [DATA_WIDTH-1:0]    i_pc,
    input  logic [ALU_OP_WIDTH-1:0]  i_aluOp,
    input  logic [DATA_WIDTH-1:0]    i_imm,
    input  logic [RF_ADDR_WIDTH-1:0] i_rdAddr,
    input  logic                     i_wbRdEn,
    input  logic [LD_TYPE_WIDTH-1:0] i_ldType,
    input  logic [ST_TYPE_WIDTH-1:0] i_stType,
    input  logic [DATA_WIDTH-1:0]    i_rs1Data,
    input  logic [DATA_WIDTH-1:0]    i_rs2Data,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_pc,
    output logic [ALU_OP_WIDTH-1:0]  o_aluOp,
    output logic [DATA_WIDTH-1:0]    o_imm,
    output logic [RF_ADDR_WIDTH-1:0] o_rdAddr,
    output logic                     o_wbRdEn,
    output logic [LD_TYPE_WIDTH-1:0] o_ldType,
    output logic [ST_TYPE_WIDTH-1:0] o_stType,
    output logic [DATA_WIDTH-1:0]    o_rs1Data,
    output logic [DATA_WIDTH-1:0]    o_rs2Data
);

    logic                     r_valid;
    logic [DATA_WIDTH-1:0]    r_pc;
    logic [ALU_OP_WIDTH-1:0]  r_aluOp;
    logic [DATA_WIDTH-1:0]    r_imm;
    logic [RF_ADDR_WIDTH-1:0] r_rdAddr;
    logic                     r_wbRdEn;
    logic [LD_TYPE_WIDTH-1:0] r_ldType;
    logic [ST_TYPE_WIDTH-1:0] r_stType;
    logic [DATA_WIDTH-1:0]    r_rs1Data;
    logic [DATA_WIDTH-1:0]    r_rs2Data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_aluOp   <= '0;
            r_imm     <= '0;
            r_rdAddr  <= '0;
            r_wbRdEn  <= 1'b0;
            r_ldType  <= LD_BUBBLE;
            r_stType  <= ST_BUBBLE;
            r_rs1Data <= '0;
            r_rs2Data <= '0;
        end else if (i_bubble) begin
            // Only the fields that can cause side effects downstream are
            // neutralised; the datapath fields are left alone.
            r_valid  <= 1'b0;
            r_wbRdEn <= 1'b0;
            r_ldType <= LD_BUBBLE;
            r_stType <= ST_BUBBLE;
        end else if (i_load) begin
            r_valid   <= i_valid;
            r_pc      <= i_pc;
            r_aluOp   <= i_aluOp;
            r_imm     <= i_imm;
            r_rdAddr  <= i_rdAddr;
            r_wbRdEn  <= i_wbRdEn;
            r_ldType  <= i_ldType;
            r_stType  <= i_stType;
            r_rs1Data <= i_rs1Data;
            r_rs2Data <= i_rs2Data;
        end
    end

    assign o_valid   = r_valid;
    assign o_pc      = r_pc;
    assign o_aluOp   = r_aluOp;
    assign o_imm     = r_imm;
    assign o_rdAddr  = r_rdAddr;
    assign o_wbRdEn  = r_wbRdEn;
    assign o_ldType  = r_ldType;
    assign o_stType  = r_stType;
    assign o_rs1Data = r_rs1Data;
    assign o_rs2Data = r_rs2Data;

endmodule
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_reg
// Purpose  : Dual-issue ID/EX pipeline register. Captures both decode slots
//            with their forwarded operands and presents them to the two
//            execute lanes. Inserts bubbles on load-use stalls, holds on
//            downstream stalls, kills on branch redirects and splits a pair
//            into two single issues when slot 1 reads slot 0's destination.
// Ports    : clk, rst (sync, active-high)
//            Decode_*_0/1, DecodeHazard_Rs*Data_0/1 - decode slot inputs
//            Decode_Rs1Addr_1/Rs2Addr_1             - slot-1 sources
//            DecodeHazard_StallReq, Ex_StallReq, Ex_Flush - pipeline control
//            IDEX_*_0/1        - registered slot outputs
//            IDEX_DecodeStall  - combinational hold request to IF/ID
//            IDEX_BubbleCnt    - saturating bubble-cycle counter
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned RF_ADDR_WIDTH = 5,
    parameter int unsigned ALU_OP_WIDTH  = 5,
    parameter int unsigned LD_TYPE_WIDTH = 3,
    parameter int unsigned ST_TYPE_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    // decode slot 0
    input  logic                      Decode_Valid_0,
    input  logic [DATA_WIDTH-1:0]     Decode_Pc_0,
    input  logic [ALU_OP_WIDTH-1:0]   Decode_AluOp_0,
    input  logic [DATA_WIDTH-1:0]     Decode_Imm_0,
    input  logic [RF_ADDR_WIDTH-1:0]  Decode_RdAddr_0,
    input  logic                      Decode_WbRdEn_0,
    input  logic [LD_TYPE_WIDTH-1:0]  Decode_LdType_0,
    input  logic [ST_TYPE_WIDTH-1:0]  Decode_StType_0,
    input  logic [DATA_WIDTH-1:0]     DecodeHazard_Rs1Data_0,
    input  logic [DATA_WIDTH-1:0]     DecodeHazard_Rs2Data_0,
    // decode slot 1
    input  logic                      Decode_Valid_1,
    input  logic [DATA_WIDTH-1:0]     Decode_Pc_1,
    input  logic [ALU_OP_WIDTH-1:0]   Decode_AluOp_1,
    input  logic [DATA_WIDTH-1:0]     Decode_Imm_1,
    input  logic [RF_ADDR_WIDTH-1:0]  Decode_RdAddr_1,
    input  logic                      Decode_WbRdEn_1,
    input  logic [RF_ADDR_WIDTH-1:0]  Decode_Rs1Addr_1,
    input  logic [RF_ADDR_WIDTH-1:0]  Decode_Rs2Addr_1,
    input  logic [LD_TYPE_WIDTH-1:0]  Decode_LdType_1,
    input  logic [ST_TYPE_WIDTH-1:0]  Decode_StType_1,
    input  logic [DATA_WIDTH-1:0]     DecodeHazard_Rs1Data_1,
    input  logic [DATA_WIDTH-1:0]     DecodeHazard_Rs2Data_1,
    // pipeline control
    input  logic                      DecodeHazard_StallReq,
    input  logic                      Ex_StallReq,
    input  logic                      Ex_Flush,
    // execute slot 0
    output logic                      IDEX_Valid_0,
    output logic [DATA_WIDTH-1:0]     IDEX_Pc_0,
    output logic [ALU_OP_WIDTH-1:0]   IDEX_AluOp_0,
    output logic [DATA_WIDTH-1:0]     IDEX_Imm_0,
    output logic [RF_ADDR_WIDTH-1:0]  IDEX_RdAddr_0,
    output logic                      IDEX_WbRdEn_0,
    output logic [LD_TYPE_WIDTH-1:0]  IDEX_LdType_0,
    output logic [ST_TYPE_WIDTH-1:0]  IDEX_StType_0,
    output logic [DATA_WIDTH-1:0]     IDEX_Rs1Data_0,
    output logic [DATA_WIDTH-1:0]     IDEX_Rs2Data_0,
    // execute slot 1
    output logic                      IDEX_Valid_1,
    output logic [DATA_WIDTH-1:0]     IDEX_Pc_1,
    output logic [ALU_OP_WIDTH-1:0]   IDEX_AluOp_1,
    output logic [DATA_WIDTH-1:0]     IDEX_Imm_1,
    output logic [RF_ADDR_WIDTH-1:0]  IDEX_RdAddr_1,
    output logic                      IDEX_WbRdEn_1,
    output logic [LD_TYPE_WIDTH-1:0]  IDEX_LdType_1,
    output logic [ST_TYPE_WIDTH-1:0]  IDEX_StType_1,
    output logic [DATA_WIDTH-1:0]     IDEX_Rs1Data_1,
    output logic [DATA_WIDTH-1:0]     IDEX_Rs2Data_1,
    // status
    output logic                      IDEX_DecodeStall,
    output logic [15:0]               IDEX_BubbleCnt
);

    localparam logic [LD_TYPE_WIDTH-1:0] c_LD_BUBBLE = LD_TYPE_WIDTH'(c_LD_XXX);
    localparam logic [ST_TYPE_WIDTH-1:0] c_ST_BUBBLE = ST_TYPE_WIDTH'(c_ST_XXX);

    logic [0:0]  r_state;
    logic [0:0]  w_stateNext;
    logic [15:0] r_bubbleCnt;
    logic        w_dep;
    logic        w_load0;
    logic        w_bubble0;
    logic        w_load1;
    logic        w_bubble1;
    logic        w_bubbleEvt;

    // Slot 1 reads a register that slot 0 of the same pair writes. x0 is
    // never a real dependency.
    assign w_dep = Decode_Valid_0 && Decode_Valid_1 &&
                   Decode_WbRdEn_0 && (Decode_RdAddr_0 != '0) &&
                   ((Decode_RdAddr_0 == Decode_Rs1Addr_1) ||
                    (Decode_RdAddr_0 == Decode_Rs2Addr_1));

    // Next-state and slot controls; the first matching condition wins.
    always_comb begin
        w_stateNext = r_state;
        w_load0     = 1'b0;
        w_bubble0   = 1'b0;
        w_load1     = 1'b0;
        w_bubble1   = 1'b0;
        w_bubbleEvt = 1'b0;
        if (Ex_Flush) begin
            w_stateNext = c_IDEX_ST_PAIR;
            w_bubble0   = 1'b1;
            w_bubble1   = 1'b1;
            w_bubbleEvt = 1'b1;
        end else if (Ex_StallReq) begin
            // everything holds
        end else if (DecodeHazard_StallReq) begin
            w_bubble0   = 1'b1;
            w_bubble1   = 1'b1;
            w_bubbleEvt = 1'b1;
        end else if ((r_state == c_IDEX_ST_PAIR) && w_dep) begin
            w_stateNext = c_IDEX_ST_SECOND;
            w_load0     = 1'b1;
            w_bubble1   = 1'b1;
            w_bubbleEvt = 1'b1;
        end else if (r_state == c_IDEX_ST_SECOND) begin
            // IF/ID held the pair, so decode still shows the same slot 1.
            w_stateNext = c_IDEX_ST_PAIR;
            w_bubble0   = 1'b1;
            w_load1     = 1'b1;
            w_bubbleEvt = 1'b1;
        end else begin
            w_load0 = 1'b1;
            w_load1 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDEX_ST_PAIR;
            r_bubbleCnt <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_bubbleEvt) begin
                r_bubbleCnt <= f_sat_inc(r_bubbleCnt);
            end
        end
    end

    // A flush discards the held pair, so IF/ID must be free to move on even
    // if a stall is requested in the same cycle.
    assign IDEX_DecodeStall = !Ex_Flush &&
                              (Ex_StallReq || DecodeHazard_StallReq ||
                               ((r_state == c_IDEX_ST_PAIR) && w_dep && !rst));

    assign IDEX_BubbleCnt = r_bubbleCnt;

    id_ex_slot #(
        .DATA_WIDTH    (DATA_WIDTH),
        .RF_ADDR_WIDTH (RF_ADDR_WIDTH),
        .ALU_OP_WIDTH  (ALU_OP_WIDTH),
        .LD_TYPE_WIDTH (LD_TYPE_WIDTH),
        .ST_TYPE_WIDTH (ST_TYPE_WIDTH),
        .LD_BUBBLE     (c_LD_BUBBLE),
        .ST_BUBBLE     (c_ST_BUBBLE)
    ) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load0),
        .i_bubble  (w_bubble0),
        .i_valid   (Decode_Valid_0),
        .i_pc      (Decode_Pc_0),
        .i_aluOp   (Decode_AluOp_0),
        .i_imm     (Decode_Imm_0),
        .i_rdAddr  (Decode_RdAddr_0),
        .i_wbRdEn  (Decode_WbRdEn_0),
        .i_ldType  (Decode_LdType_0),
        .i_stType  (Decode_StType_0),
        .i_rs1Data (DecodeHazard_Rs1Data_0),
        .i_rs2Data (DecodeHazard_Rs2Data_0),
        .o_valid   (IDEX_Valid_0),
        .o_pc      (IDEX_Pc_0),
        .o_aluOp   (IDEX_AluOp_0),
        .o_imm     (IDEX_Imm_0),
        .o_rdAddr  (IDEX_RdAddr_0),
        .o_wbRdEn  (IDEX_WbRdEn_0),
        .o_ldType  (IDEX_LdType_0),
        .o_stType  (IDEX_StType_0),
        .o_rs1Data (IDEX_Rs1Data_0),
        .o_rs2Data (IDEX_Rs2Data_0)
    );

    id_ex_slot #(
        .DATA_WIDTH    (DATA_WIDTH),
        .RF_ADDR_WIDTH (RF_ADDR_WIDTH),
        .ALU_OP_WIDTH  (ALU_OP_WIDTH),
        .LD_TYPE_WIDTH (LD_TYPE_WIDTH),
        .ST_TYPE_WIDTH (ST_TYPE_WIDTH),
        .LD_BUBBLE     (c_LD_BUBBLE),
        .ST_BUBBLE     (c_ST_BUBBLE)
    ) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load1),
        .i_bubble  (w_bubble1),
        .i_valid   (Decode_Valid_1),
        .i_pc      (Decode_Pc_1),
        .i_aluOp   (Decode_AluOp_1),
        .i_imm     (Decode_Imm_1),
        .i_rdAddr  (Decode_RdAddr_1),
        .i_wbRdEn  (Decode_WbRdEn_1),
        .i_ldType  (Decode_LdType_1),
        .i_stType  (Decode_StType_1),
        .i_rs1Data (DecodeHazard_Rs1Data_1),
        .i_rs2Data (DecodeHazard_Rs2Data_1),
        .o_valid   (IDEX_Valid_1),
        .o_pc      (IDEX_Pc_1),
        .o_aluOp   (IDEX_AluOp_1),
        .o_imm     (IDEX_Imm_1),
        .o_rdAddr  (IDEX_RdAddr_1),
        .o_wbRdEn  (IDEX_WbRdEn_1),
        .o_ldType  (IDEX_LdType_1),
        .o_stType  (IDEX_StType_1),
        .o_rs1Data (IDEX_Rs1Data_1),
        .o_rs2Data (IDEX_Rs2Data_1)
    );

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_reg
// Purpose  : Directed scoreboard bench for id_ex_reg. The stimulus process
//            drives one decode pair per cycle and queues the outputs expected
//            after the next clock edge; a monitor process pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_reg;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  ld;
        logic [1:0]  st;
    } slot_t;

    typedef struct {
        string       name;
        slot_t       s0;
        slot_t       s1;
        logic [15:0] cnt;
        bit          isReset;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        dV0, dV1, dWe0, dWe1;
    logic [31:0] dPc0, dPc1, dImm0, dImm1, dR1d0, dR2d0, dR1d1, dR2d1;
    logic [4:0]  dAlu0, dAlu1, dRd0, dRd1, dRs1_1, dRs2_1;
    logic [2:0]  dLd0, dLd1;
    logic [1:0]  dSt0, dSt1;
    logic        dhStall = 1'b0, exStall = 1'b0, exFlush = 1'b0;

    logic        oV0, oV1, oWe0, oWe1, oStall;
    logic [31:0] oPc0, oPc1, oImm0, oImm1, oR1d0, oR2d0, oR1d1, oR2d1;
    logic [4:0]  oAlu0, oAlu1, oRd0, oRd1;
    logic [2:0]  oLd0, oLd1;
    logic [1:0]  oSt0, oSt1;
    logic [15:0] oCnt;

    int   nCmp = 0;
    int   nErr = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst(rst),
        .Decode_Valid_0(dV0), .Decode_Pc_0(dPc0), .Decode_AluOp_0(dAlu0),
        .Decode_Imm_0(dImm0), .Decode_RdAddr_0(dRd0), .Decode_WbRdEn_0(dWe0),
        .Decode_LdType_0(dLd0), .Decode_StType_0(dSt0),
        .DecodeHazard_Rs1Data_0(dR1d0), .DecodeHazard_Rs2Data_0(dR2d0),
        .Decode_Valid_1(dV1), .Decode_Pc_1(dPc1), .Decode_AluOp_1(dAlu1),
        .Decode_Imm_1(dImm1), .Decode_RdAddr_1(dRd1), .Decode_WbRdEn_1(dWe1),
        .Decode_Rs1Addr_1(dRs1_1), .Decode_Rs2Addr_1(dRs2_1),
        .Decode_LdType_1(dLd1), .Decode_StType_1(dSt1),
        .DecodeHazard_Rs1Data_1(dR1d1), .DecodeHazard_Rs2Data_1(dR2d1),
        .DecodeHazard_StallReq(dhStall), .Ex_StallReq(exStall), .Ex_Flush(exFlush),
        .IDEX_Valid_0(oV0), .IDEX_Pc_0(oPc0), .IDEX_AluOp_0(oAlu0), .IDEX_Imm_0(oImm0),
        .IDEX_RdAddr_0(oRd0), .IDEX_WbRdEn_0(oWe0), .IDEX_LdType_0(oLd0),
        .IDEX_StType_0(oSt0), .IDEX_Rs1Data_0(oR1d0), .IDEX_Rs2Data_0(oR2d0),
        .IDEX_Valid_1(oV1), .IDEX_Pc_1(oPc1), .IDEX_AluOp_1(oAlu1), .IDEX_Imm_1(oImm1),
        .IDEX_RdAddr_1(oRd1), .IDEX_WbRdEn_1(oWe1), .IDEX_LdType_1(oLd1),
        .IDEX_StType_1(oSt1), .IDEX_Rs1Data_1(oR1d1), .IDEX_Rs2Data_1(oR2d1),
        .IDEX_DecodeStall(oStall), .IDEX_BubbleCnt(oCnt)
    );

    // Secondary fields are derived from the PC so every slot is distinct.
    function automatic logic [4:0]  fAlu(input logic [31:0] pc); return pc[6:2]; endfunction
    function automatic logic [31:0] fImm(input logic [31:0] pc); return pc ^ 32'hA5A5_0000; endfunction
    function automatic logic [31:0] fR1(input logic [31:0] pc);  return pc + 32'h1000; endfunction
    function automatic logic [31:0] fR2(input logic [31:0] pc);  return pc + 32'h2000; endfunction

    function automatic slot_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                                 input logic we, input logic [2:0] ld, input logic [1:0] st);
        slot_t s;
        s.v = v; s.pc = pc; s.rd = rd; s.we = we; s.ld = ld; s.st = st;
        return s;
    endfunction

    function automatic slot_t bub();
        return mk(1'b0, 32'h0, 5'd0, 1'b0, 3'b000, 2'b00);
    endfunction

    function automatic exp_t mkE(input string nm, input slot_t a, input slot_t b,
                                 input logic [15:0] c, input bit r);
        exp_t e;
        e.name = nm; e.s0 = a; e.s1 = b; e.cnt = c; e.isReset = r;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic setDec(input slot_t a, input slot_t b, input logic [4:0] rs1, input logic [4:0] rs2);
        dV0 = a.v; dPc0 = a.pc; dRd0 = a.rd; dWe0 = a.we; dLd0 = a.ld; dSt0 = a.st;
        dAlu0 = fAlu(a.pc); dImm0 = fImm(a.pc); dR1d0 = fR1(a.pc); dR2d0 = fR2(a.pc);
        dV1 = b.v; dPc1 = b.pc; dRd1 = b.rd; dWe1 = b.we; dLd1 = b.ld; dSt1 = b.st;
        dAlu1 = fAlu(b.pc); dImm1 = fImm(b.pc); dR1d1 = fR1(b.pc); dR2d1 = fR2(b.pc);
        dRs1_1 = rs1; dRs2_1 = rs2;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic cycle(input logic expStall, input exp_t e, input bit doCheck);
        #1;
        if (doCheck) begin
            chk({e.name, " DecodeStall"}, {31'd0, oStall}, {31'd0, expStall});
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chkSlot(input string nm, input slot_t e, input bit isReset,
                           input logic v, input logic [31:0] pc, input logic [4:0] alu,
                           input logic [31:0] imm, input logic [4:0] rd, input logic we,
                           input logic [2:0] ld, input logic [1:0] st,
                           input logic [31:0] r1, input logic [31:0] r2);
        chk({nm, " Valid"},  {31'd0, v},  {31'd0, e.v});
        chk({nm, " WbRdEn"}, {31'd0, we}, {31'd0, e.we});
        chk({nm, " LdType"}, {29'd0, ld}, {29'd0, e.ld});
        chk({nm, " StType"}, {30'd0, st}, {30'd0, e.st});
        if (isReset) begin
            chk({nm, " Pc"}, pc, 32'h0);
            chk({nm, " AluOp"}, {27'd0, alu}, 32'h0);
            chk({nm, " Imm"}, imm, 32'h0);
            chk({nm, " RdAddr"}, {27'd0, rd}, 32'h0);
            chk({nm, " Rs1Data"}, r1, 32'h0);
            chk({nm, " Rs2Data"}, r2, 32'h0);
        end else if (e.v) begin
            chk({nm, " Pc"}, pc, e.pc);
            chk({nm, " AluOp"}, {27'd0, alu}, {27'd0, fAlu(e.pc)});
            chk({nm, " Imm"}, imm, fImm(e.pc));
            chk({nm, " RdAddr"}, {27'd0, rd}, {27'd0, e.rd});
            chk({nm, " Rs1Data"}, r1, fR1(e.pc));
            chk({nm, " Rs2Data"}, r2, fR2(e.pc));
        end
    endtask

    // Monitor: the register presents a new result after every clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chkSlot({e.name, " s0"}, e.s0, e.isReset, oV0, oPc0, oAlu0, oImm0, oRd0,
                        oWe0, oLd0, oSt0, oR1d0, oR2d0);
                chkSlot({e.name, " s1"}, e.s1, e.isReset, oV1, oPc1, oAlu1, oImm1, oRd1,
                        oWe1, oLd1, oSt1, oR1d1, oR2d1);
                chk({e.name, " BubbleCnt"}, {16'd0, oCnt}, {16'd0, e.cnt});
            end
        end
    end

    initial begin
        slot_t a, b, bb;
        bb = bub();
        setDec(bb, bb, 5'd0, 5'd0);
        @(negedge clk);

        // Reset with no decode activity.
        rst = 1'b1;
        cycle(1'b0, mkE("reset0", bb, bb, 16'd0, 1'b1), 1'b1);
        cycle(1'b0, mkE("reset1", bb, bb, 16'd0, 1'b1), 1'b1);
        rst = 1'b0;
        cycle(1'b0, mkE("idle", bb, bb, 16'd0, 1'b0), 1'b1);

        // Independent pair: x5 <- x1+x2, x6 <- x3+x4 (slot 1 also a store type).
        a = mk(1'b1, 32'h100, 5'd5, 1'b1, 3'b000, 2'b00);
        b = mk(1'b1, 32'h104, 5'd6, 1'b1, 3'b000, 2'b10);
        setDec(a, b, 5'd3, 5'd4);
        cycle(1'b0, mkE("indep", a, b, 16'd0, 1'b0), 1'b1);

        // Dependent pair: slot 0 loads x5, slot 1 reads x5 -> split over two cycles.
        a = mk(1'b1, 32'h200, 5'd5, 1'b1, 3'b010, 2'b00);
        b = mk(1'b1, 32'h204, 5'd7, 1'b1, 3'b000, 2'b00);
        setDec(a, b, 5'd5, 5'd0);
        cycle(1'b1, mkE("dep1", a, bb, 16'd1, 1'b0), 1'b1);
        cycle(1'b0, mkE("dep2", bb, b, 16'd2, 1'b0), 1'b1);

        // Writes to x0 never create a dependency.
        a = mk(1'b1, 32'h240, 5'd0, 1'b1, 3'b000, 2'b00);
        b = mk(1'b1, 32'h244, 5'd8, 1'b1, 3'b000, 2'b00);
        setDec(a, b, 5'd0, 5'd0);
        cycle(1'b0, mkE("x0nodep", a, b, 16'd2, 1'b0), 1'b1);

        // Load-use stall for one cycle, then the pair issues.
        a = mk(1'b1, 32'h300, 5'd9, 1'b1, 3'b000, 2'b00);
        b = mk(1'b1, 32'h304, 5'd10, 1'b1, 3'b000, 2'b00);
        setDec(a, b, 5'd1, 5'd2);
        cycle(1'b0, mkE("pre300", a, b, 16'd2, 1'b0), 1'b1);
        a = mk(1'b1, 32'h400, 5'd11, 1'b1, 3'b100, 2'b00);
        b = mk(1'b1, 32'h404, 5'd12, 1'b0, 3'b000, 2'b01);
        setDec(a, b, 5'd1, 5'd2);
        dhStall = 1'b1;
        cycle(1'b1, mkE("ldstall", bb, bb, 16'd3, 1'b0), 1'b1);
        dhStall = 1'b0;
        cycle(1'b0, mkE("after_ld", a, b, 16'd3, 1'b0), 1'b1);

        // Downstream hold beats the load-use stall: outputs and counter unchanged.
        setDec(mk(1'b1, 32'h500, 5'd13, 1'b1, 3'b000, 2'b00),
               mk(1'b1, 32'h504, 5'd14, 1'b1, 3'b000, 2'b00), 5'd1, 5'd2);
        dhStall = 1'b1; exStall = 1'b1;
        cycle(1'b1, mkE("hold", a, b, 16'd3, 1'b0), 1'b1);
        dhStall = 1'b0; exStall = 1'b0;
        a = mk(1'b1, 32'h500, 5'd13, 1'b1, 3'b000, 2'b00);
        b = mk(1'b1, 32'h504, 5'd14, 1'b1, 3'b000, 2'b00);
        cycle(1'b0, mkE("release", a, b, 16'd3, 1'b0), 1'b1);

        // Split, hold in SECOND, then flush with the hold still asserted.
        a = mk(1'b1, 32'h600, 5'd15, 1'b1, 3'b000, 2'b00);
        b = mk(1'b1, 32'h604, 5'd16, 1'b1, 3'b000, 2'b00);
        setDec(a, b, 5'd1, 5'd15);
        cycle(1'b1, mkE("split600", a, bb, 16'd4, 1'b0), 1'b1);
        exStall = 1'b1;
        cycle(1'b1, mkE("holdSecond", a, bb, 16'd4, 1'b0), 1'b1);
        exFlush = 1'b1;
        cycle(1'b0, mkE("flush", bb, bb, 16'd5, 1'b0), 1'b1);
        exFlush = 1'b0; exStall = 1'b0;
        // Back in PAIR: the same dependent pair splits again.
        cycle(1'b1, mkE("resplit", a, bb, 16'd6, 1'b0), 1'b1);
        // Load-use stall in SECOND: bubble, state stays SECOND.
        dhStall = 1'b1;
        cycle(1'b1, mkE("ldSecond", bb, bb, 16'd7, 1'b0), 1'b1);
        dhStall = 1'b0;
        cycle(1'b0, mkE("second", bb, b, 16'd8, 1'b0), 1'b1);

        // Reset mid-split returns to PAIR.
        a = mk(1'b1, 32'h700, 5'd17, 1'b1, 3'b000, 2'b00);
        b = mk(1'b1, 32'h704, 5'd18, 1'b1, 3'b000, 2'b00);
        setDec(a, b, 5'd17, 5'd17);
        cycle(1'b1, mkE("split700", a, bb, 16'd9, 1'b0), 1'b1);
        rst = 1'b1;
        cycle(1'b0, mkE("midReset", bb, bb, 16'd0, 1'b1), 1'b1);
        rst = 1'b0;
        cycle(1'b1, mkE("postRst1", a, bb, 16'd1, 1'b0), 1'b1);
        cycle(1'b0, mkE("postRst2", bb, b, 16'd2, 1'b0), 1'b1);

        // Saturation: 65540 load-use stall cycles take the counter past 0xFFFF.
        dhStall = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            cycle(1'b1, mkE("sat", bb, bb, 16'hFFFF, 1'b0), 1'b0);
        end
        cycle(1'b1, mkE("satHold", bb, bb, 16'hFFFF, 1'b0), 1'b1);
        dhStall = 1'b0; exFlush = 1'b1;
        cycle(1'b0, mkE("satFlush", bb, bb, 16'hFFFF, 1'b0), 1'b1);
        exFlush = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_reg.md
# id_ex_reg

Dual-issue ID/EX pipeline register. It captures both decode slots together with their forwarded operands from the decode-stage hazard/forwarding unit, and presents them to the two execute lanes. It also implements bubble insertion on load-use stalls, holds on downstream stalls and kills on branch redirects. It splits a pair into two single issues when slot 1 depends on slot 0's destination register.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/immediate/PC width
- RF_ADDR_WIDTH, 5, register address width
- ALU_OP_WIDTH, 5, ALU opcode width
- LD_TYPE_WIDTH, 3, load type width (`LD_XXX` = not a load)
- ST_TYPE_WIDTH, 2, store type width (`ST_XXX` = not a store)

Ports (i ∈ {0,1}, one set per slot):
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset. Synchronous, active-high.
- Decode_Valid_i  in  1  slot holds a real instruction
- Decode_Pc_i  in  DATA_WIDTH  instruction PC
- Decode_AluOp_i  in  ALU_OP_WIDTH  ALU operation
- Decode_Imm_i  in  DATA_WIDTH  immediate
- Decode_RdAddr_i  in  RF_ADDR_WIDTH  destination register
- Decode_WbRdEn_i  in  1  destination write enable
- Decode_Rs1Addr_1, Decode_Rs2Addr_1  in  RF_ADDR_WIDTH  slot-1 source registers, used for the intra-pair check
- Decode_LdType_i  in  LD_TYPE_WIDTH;  Decode_StType_i  in  ST_TYPE_WIDTH
- DecodeHazard_Rs1Data_i, DecodeHazard_Rs2Data_i  in  DATA_WIDTH  forwarded operands
- DecodeHazard_StallReq  in  1  load-use stall request
- Ex_StallReq  in  1  downstream hold (EX/MEM not accepting)
- Ex_Flush  in  1  branch redirect. Kills the contents of ID/EX.
- IDEX_Valid_i, IDEX_Pc_i, IDEX_AluOp_i, IDEX_Imm_i, IDEX_RdAddr_i, IDEX_WbRdEn_i, IDEX_LdType_i, IDEX_StType_i, IDEX_Rs1Data_i, IDEX_Rs2Data_i  out  registered copies of the corresponding slot inputs
- IDEX_DecodeStall  out  1  combinational. Instructs IF/ID to hold its pair.
- IDEX_BubbleCnt  out  16  saturating count of bubble cycles (performance monitoring)

## Operation
- Bubble definition: Valid=0, WbRdEn=0, LdType=`LD_XXX`, StType=`ST_XXX`. Data fields hold their previous values (don't-care).
- Intra-pair dependency (`dep`) is true when all of the following hold:
  - Decode_Valid_0 and Decode_Valid_1 are both set;
  - Decode_WbRdEn_0 is set and Decode_RdAddr_0 ≠ 0;
  - Decode_RdAddr_0 equals Decode_Rs1Addr_1 or Decode_Rs2Addr_1.
- FSM states:
  - PAIR (reset state)
  - SECOND: slot 0 of the current decode pair has already been issued.
- Per-cycle action, first matching rule wins:
  1. rst: state←PAIR, both slots←bubble, BubbleCnt←0.
  2. Ex_Flush: state←PAIR, both slots←bubble. Overrides every stall.
  3. Ex_StallReq: all registers and state hold.
  4. DecodeHazard_StallReq: both slots←bubble, state holds.
  5. PAIR with dep: slot 0←decode slot 0, slot 1←bubble, state←SECOND.
  6. SECOND: slot 0←bubble, slot 1←decode slot 1, state←PAIR.
  7. Otherwise: both slots load from decode.
- IDEX_DecodeStall = !Ex_Flush && (Ex_StallReq || DecodeHazard_StallReq || (state==PAIR && dep && !rst)).
- BubbleCnt increments by 1, saturating at 0xFFFF, in every non-reset cycle where rule 2, 4, 5 or 6 fires.

## Timing
- Latency: one cycle from decode inputs to IDEX outputs. All outputs except IDEX_DecodeStall are registered.
- Reset values:
  - all IDEX_Valid_i, IDEX_WbRdEn_i = 0;
  - LdType = `LD_XXX`, StType = `ST_XXX`;
  - data, PC, AluOp, RdAddr = 0;
  - BubbleCnt = 0.
- In SECOND, decode presents the same pair, because IF/ID was held. Slot-1 operands then forward from EX lane 0 through the hazard unit.
- Ex_Flush in the same cycle as a split: the split is aborted and state returns to PAIR.
- Ex_StallReq while in SECOND: state stays SECOND and IDEX_DecodeStall stays asserted.
- DecodeHazard_StallReq while in SECOND: bubble is inserted and state stays SECOND.
- Reset asserted mid-split: state returns to PAIR on the next edge.

## Structure
- The shared Define.v header carries:
  - `LD_XXX`, `ST_XXX` and the type-width macros;
  - state encodings `IDEX_ST_PAIR`=1'b0 and `IDEX_ST_SECOND`=1'b1.
- Sub-module `id_ex_slot`: one per slot. It is a field register with load, hold and bubble controls. The FSM, dependency check and counter stay in the top level.

## Test plan
- Reset, then no decode activity: all Valid=0, LdType=`LD_XXX`, BubbleCnt=0.
- Independent pair (slot 0: x5←x1+x2, slot 1: x6←x3+x4): both slots valid one cycle later; IDEX_DecodeStall=0.
- Dependent pair (slot 0 writes x5, slot 1 reads x5):
  - cycle 1: slot 0 valid, slot 1 bubble, DecodeStall=1;
  - cycle 2: slot 0 bubble, slot 1 valid, DecodeStall=0;
  - BubbleCnt=2.
- DecodeHazard_StallReq pulsed for 1 cycle: both slots bubble for 1 cycle and BubbleCnt+1; with Ex_StallReq also high, outputs hold and the counter is unchanged.
- Ex_Flush while in SECOND with Ex_StallReq=1: next cycle both slots bubble, state=PAIR, DecodeStall=0 during the flush cycle.
- BubbleCnt preloaded near saturation by 65540 stall cycles: value stays at 0xFFFF.
